// File: rtl/xor_checksum_ctrl_pkg.sv
// xor_checksum_ctrl shared types
// FSM encodings and datapath width
package xor_checksum_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/xor_checksum_ctrl_xor.sv
// 32-bit bitwise XOR gate array
// shared datapath block, purely combinational
module _32_bit_xor
  import xor_checksum_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_checksum_ctrl.sv
// xor_checksum_ctrl: folds a memory block into one
// XOR checksum over a req/gnt/rvalid read port
module xor_checksum_ctrl
  import xor_checksum_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] seed,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  state_e            state;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_inc;

  assign addr_inc = addr + ADDR_W'(1);

  _32_bit_xor acc_xor (
    .a (acc),
    .b (mem_rdata),
    .y (acc_nxt)
  );

  // sequencer: state, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      cnt      <= '0;
      addr     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      checksum <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc  <= seed;
            addr <= base_addr;
            cnt  <= len;
            busy <= 1'b1;
            if (len == '0) begin
              state    <= S_DONE;
              checksum <= seed;
              done     <= 1'b1;
            end else begin
              state    <= S_REQ;
              mem_req  <= 1'b1;
              mem_addr <= base_addr;
            end
          end
        end
        S_REQ: begin
          if (abort) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            busy    <= 1'b0;
          end else if (mem_gnt) begin
            state   <= S_WAIT;
            mem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (mem_rvalid) begin
            acc  <= acc_nxt;
            cnt  <= cnt - ADDR_W'(1);
            addr <= addr_inc;
            if (cnt == ADDR_W'(1)) begin
              state    <= S_DONE;
              checksum <= acc_nxt;
              done     <= 1'b1;
            end else begin
              state    <= S_REQ;
              mem_req  <= 1'b1;
              mem_addr <= addr_inc;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
